sfr_bus_arbiter: RTL and testbench

Two-port round-robin arbiter and bus sequencer that shares the single SFR register port between the CPU core (port 0) and the debug/loader monitor (port 1). It turns each requester's req/ack transaction into a glitch-free, registered SFR access with stable address and data. For writes, it drives a one-flop `sfr_write_valid` strobe with setup and hold margin, because the SFR file latches on the strobe edge. For reads, it samples `sfr_read_val` and returns it to the winner. It sits between the core/monitor and the SFR file.

---
 rtl/sfr_bus_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 15 +
 rtl/sfr_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_sfr_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfr_bus_pkg.sv
// Shared types and widths for the SFR bus arbiter slice.
package sfr_bus_pkg;

  localparam int SFR_ADDR_W = 8;
  localparam int SFR_DATA_W = 8;

  typedef enum logic [2:0] {
    SFR_IDLE   = 3'd0,
    SFR_SETUP  = 3'd1,
    SFR_STROBE = 3'd2,
    SFR_HOLD   = 3'd3,
    SFR_DONE   = 3'd4
  } sfr_bus_state_t;

  typedef struct packed {
    logic                  we;
    logic [SFR_ADDR_W-1:0] addr;
    logic [SFR_DATA_W-1:0] wdata;
  } sfr_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the port not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = req[1];
    if (&req) grant_id = ~last_grant;
  end

endmodule

// File: rtl/sfr_bus_arbiter.sv
// Shares the SFR register port between core (port 0) and monitor (port 1),
// sequencing each access as SETUP / STROBE / HOLD / DONE with registered outputs.
module sfr_bus_arbiter
  import sfr_bus_pkg::*;
#(
  parameter int WR_PULSE = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  rq0_req,
  input  logic                  rq0_we,
  input  logic [SFR_ADDR_W-1:0] rq0_addr,
  input  logic [SFR_DATA_W-1:0] rq0_wdata,
  output logic                  rq0_ack,
  output logic [SFR_DATA_W-1:0] rq0_rdata,
  input  logic                  rq1_req,
  input  logic                  rq1_we,
  input  logic [SFR_ADDR_W-1:0] rq1_addr,
  input  logic [SFR_DATA_W-1:0] rq1_wdata,
  output logic                  rq1_ack,
  output logic [SFR_DATA_W-1:0] rq1_rdata,
  output logic [SFR_ADDR_W-1:0] sfr_addr,
  output logic [SFR_DATA_W-1:0] sfr_write_val,
  output logic                  sfr_write_valid,
  input  logic [SFR_DATA_W-1:0] sfr_read_val,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE   = SFR_IDLE;
  localparam logic [2:0] S_SETUP  = SFR_SETUP;
  localparam logic [2:0] S_STROBE = SFR_STROBE;
  localparam logic [2:0] S_HOLD   = SFR_HOLD;
  localparam logic [2:0] S_DONE   = SFR_DONE;

  generate
    if (WR_PULSE < 1 || WR_PULSE > 15) begin : g_bad_pulse
      $error("sfr_bus_arbiter: WR_PULSE must be in 1..15");
    end
  endgenerate

  logic [2:0] state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       cur_id;
  logic       cur_we;
  logic       gnt_valid;
  logic       gnt_id;
  sfr_req_t   req_sel;

  rr_arbiter2 u_arb (
    .req        ({rq1_req, rq0_req}),
    .last_grant (last_grant),
    .grant_valid(gnt_valid),
    .grant_id   (gnt_id)
  );

  always_comb begin
    req_sel = {rq0_we, rq0_addr, rq0_wdata};
    if (gnt_id) req_sel = {rq1_we, rq1_addr, rq1_wdata};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= S_IDLE;
      last_grant      <= 1'b1;
      cur_id          <= 1'b0;
      cur_we          <= 1'b0;
      cnt             <= 4'd0;
      sfr_addr        <= '0;
      sfr_write_val   <= '0;
      sfr_write_valid <= 1'b0;
      rq0_rdata       <= '0;
      rq1_rdata       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            state         <= S_SETUP;
            last_grant    <= gnt_id;
            cur_id        <= gnt_id;
            cur_we        <= req_sel.we;
            sfr_addr      <= req_sel.addr;
            sfr_write_val <= req_sel.wdata;
            cnt           <= 4'd0;
          end
        end
        S_SETUP: begin
          if (cur_we) begin
            state           <= S_STROBE;
            sfr_write_valid <= 1'b1;
            cnt             <= 4'(WR_PULSE - 1);
          end else if (cnt == 4'd0) begin
            // one settle cycle so sfr_read_val reflects the new address
            cnt <= 4'd1;
          end else begin
            state <= S_DONE;
            if (cur_id) rq1_rdata <= sfr_read_val;
            else        rq0_rdata <= sfr_read_val;
          end
        end
        S_STROBE: begin
          if (cnt == 4'd0) begin
            state           <= S_HOLD;
            sfr_write_valid <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD:  state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: begin
          state           <= S_IDLE;
          sfr_write_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign rq0_ack = (state == S_DONE) && !cur_id;
  assign rq1_ack = (state == S_DONE) &&  cur_id;

endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Directed scoreboard bench: two instances (WR_PULSE=1 and WR_PULSE=4).
module tb_sfr_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       rq0_req, rq0_we, rq1_req, rq1_we;
  logic [7:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
  logic       rq0_ack, rq1_ack;
  logic [7:0] rq0_rdata, rq1_rdata, sfr_addr, sfr_write_val, sfr_read_val;
  logic       sfr_write_valid, busy;

  logic       b_req, b_we;
  logic [7:0] b_addr, b_wdata;
  logic       b_ack, b_ack1, b_wvalid, b_busy;
  logic [7:0] b_rdata0, b_rdata1, b_sfr_addr, b_wval, b_rval;

  // SFR file model: read data is a fixed function of the address
  assign sfr_read_val = sfr_addr ^ 8'h36;
  assign b_rval       = b_sfr_addr ^ 8'h36;

  sfr_bus_arbiter #(.WR_PULSE(1)) u_dut (
    .clk(clk), .nrst(nrst),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
    .sfr_addr(sfr_addr), .sfr_write_val(sfr_write_val), .sfr_write_valid(sfr_write_valid),
    .sfr_read_val(sfr_read_val), .busy(busy)
  );

  sfr_bus_arbiter #(.WR_PULSE(4)) u_dut4 (
    .clk(clk), .nrst(nrst),
    .rq0_req(b_req), .rq0_we(b_we), .rq0_addr(b_addr), .rq0_wdata(b_wdata),
    .rq0_ack(b_ack), .rq0_rdata(b_rdata0),
    .rq1_req(1'b0), .rq1_we(1'b0), .rq1_addr(8'h00), .rq1_wdata(8'h00),
    .rq1_ack(b_ack1), .rq1_rdata(b_rdata1),
    .sfr_addr(b_sfr_addr), .sfr_write_val(b_wval), .sfr_write_valid(b_wvalid),
    .sfr_read_val(b_rval), .busy(b_busy)
  );

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t q[$];
  exp_t qb[$];
  int checks = 0;
  int errs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor, instance A ----------------
  exp_t       em;
  logic [7:0] addr_prev = 8'h00, seen_addr = 8'h00, seen_data = 8'h00;
  logic       wv_prev = 1'b0, busy_prev = 1'b0, pend_wr = 1'b0;
  int         hi_cnt = 0;

  always @(negedge clk) begin
    if (!nrst) begin
      hi_cnt  = 0;
      pend_wr = 1'b0;
    end else begin
      if (busy && busy_prev) chk("addr_stable", sfr_addr, addr_prev);
      if (sfr_write_valid) begin
        if (!wv_prev) begin
          chk("strobe_addr_settled", sfr_addr, addr_prev);
          seen_addr = sfr_addr;
          seen_data = sfr_write_val;
          pend_wr   = 1'b1;
        end
        hi_cnt++;
      end else if (wv_prev) begin
        chk("strobe_width", hi_cnt, 1);
        hi_cnt = 0;
      end
      if (rq0_ack || rq1_ack) begin
        chk("ack_onehot", rq0_ack & rq1_ack, 0);
        chk("ack_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          em = q.pop_front();
          chk("ack_port", rq1_ack, em.port);
          chk("ack_addr", sfr_addr, em.addr);
          if (em.we) begin
            chk("wr_strobed", pend_wr, 1);
            chk("wr_addr", seen_addr, em.addr);
            chk("wr_data", seen_data, em.wdata);
          end else begin
            chk("rd_no_strobe", pend_wr, 0);
            chk("rd_data", (em.port == 1) ? rq1_rdata : rq0_rdata, em.rdata);
          end
          pend_wr = 1'b0;
        end
      end
    end
    addr_prev = sfr_addr;
    wv_prev   = sfr_write_valid;
    busy_prev = busy;
  end

  // ---------------- monitor, instance B ----------------
  exp_t       ebm;
  logic [7:0] b_seen_a = 8'h00, b_seen_d = 8'h00;
  logic       bwv_prev = 1'b0;
  int         b_hi = 0;

  always @(negedge clk) begin
    if (nrst) begin
      if (b_wvalid) begin
        if (!bwv_prev) begin
          b_seen_a = b_sfr_addr;
          b_seen_d = b_wval;
        end
        b_hi++;
      end else if (bwv_prev) begin
        chk("b_strobe_width", b_hi, 4);
        b_hi = 0;
      end
      if (b_ack) begin
        chk("b_ack_expected", qb.size() != 0, 1);
        if (qb.size() != 0) begin
          ebm = qb.pop_front();
          chk("b_wr_addr", b_seen_a, ebm.addr);
          chk("b_wr_data", b_seen_d, ebm.wdata);
        end
      end
    end
    bwv_prev = b_wvalid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input int p, input logic r, input logic we,
                          input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin rq0_req = r; rq0_we = we; rq0_addr = a; rq0_wdata = d; end
    else        begin rq1_req = r; rq1_we = we; rq1_addr = a; rq1_wdata = d; end
  endtask

  task automatic push_exp(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.port = p; e.we = we; e.addr = a; e.wdata = d; e.rdata = a ^ 8'h36;
    q.push_back(e);
  endtask

  // Single transaction on instance A (WR_PULSE=1) with cycle-exact checks; k = edge index.
  task automatic timed_a(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    int last;
    push_exp(p, we, a, d);
    last = we ? 3 : 2;
    @(posedge clk); #1;
    set_port(p, 1'b1, we, a, d);
    for (int k = 0; k <= last + 1; k++) begin
      @(posedge clk); #1;
      chk("t_busy",   busy, k <= last);
      chk("t_strobe", sfr_write_valid, we && k == 1);
      chk("t_ack0",   rq0_ack, p == 0 && k == last);
      chk("t_ack1",   rq1_ack, p == 1 && k == last);
      if (k <= last) chk("t_addr", sfr_addr, a);
      if (k == last) begin
        if (p == 0) rq0_req = 1'b0; else rq1_req = 1'b0;
      end
    end
  endtask

  task automatic wait_ack(input int p, input string nm);
    int n;
    n = 0;
    while (!((p == 1) ? rq1_ack : rq0_ack) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, n < 20, 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_addr"},   sfr_addr, 0);
    chk({tag, "_wval"},   sfr_write_val, 0);
    chk({tag, "_strobe"}, sfr_write_valid, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_acks"},   {rq0_ack, rq1_ack}, 0);
    chk({tag, "_rdata"},  {rq0_rdata, rq1_rdata}, 0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    reset_checks("rst");
    @(negedge clk); #2;
    nrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n0, n1;
    nrst = 1'b0;
    set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("init");
    chk("init_b_busy", b_busy, 0);
    @(negedge clk); #2;
    nrst = 1'b1;

    // single write, single read
    timed_a(0, 1'b1, 8'h05, 8'h80);
    timed_a(1, 1'b0, 8'h0A, 8'h5F);

    // contention after reset: strict alternation 0,1,0,1,0,1 with fresh fields
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 1'b1, 8'(8'h10 + 2 * i), 8'(8'hA0 + i));
      push_exp(1, 1'b1, 8'(8'h11 + 2 * i), 8'(8'hB0 + i));
    end
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b1, 8'h10, 8'hA0);
    set_port(1, 1'b1, 1'b1, 8'h11, 8'hB0);
    n0 = 0; n1 = 0;
    for (int c = 0; c < 100 && (n0 < 3 || n1 < 3); c++) begin
      @(posedge clk); #1;
      if (rq0_ack) begin
        n0++;
        if (n0 == 3) rq0_req = 1'b0;
        else begin rq0_addr = 8'(8'h10 + 2 * n0); rq0_wdata = 8'(8'hA0 + n0); end
      end
      if (rq1_ack) begin
        n1++;
        if (n1 == 3) rq1_req = 1'b0;
        else begin rq1_addr = 8'(8'h11 + 2 * n1); rq1_wdata = 8'(8'hB0 + n1); end
      end
    end
    chk("cont_port0_done", n0, 3);
    chk("cont_port1_done", n1, 3);
    @(posedge clk); #1;

    // WR_PULSE=4 on instance B: strobe after edges 1..4, ack after edge 6, idle after 7
    begin
      exp_t e;
      e.port = 0; e.we = 1'b1; e.addr = 8'h33; e.wdata = 8'hC5; e.rdata = 8'h00;
      qb.push_back(e);
    end
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h33; b_wdata = 8'hC5;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clk); #1;
      chk("b_busy",   b_busy, k <= 6);
      chk("b_strobe", b_wvalid, k >= 1 && k <= 4);
      chk("b_ack",    b_ack, k == 6);
      if (k == 6) b_req = 1'b0;
    end

    // loser changes its address every cycle; only its own IDLE grant edge samples it
    push_exp(0, 1'b1, 8'h44, 8'h5A);
    push_exp(1, 1'b0, 8'h2B, 8'h00);
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b1, 8'h44, 8'h5A);
    @(posedge clk); #1;
    rq1_req = 1'b1; rq1_we = 1'b0; rq1_wdata = 8'h00;
    for (int c = 0; c < 20 && !rq0_ack; c++) begin
      rq1_addr = 8'(8'hE0 + c);
      @(posedge clk); #1;
    end
    chk("loser_winner_ack", rq0_ack, 1);
    rq0_req  = 1'b0;
    rq1_addr = 8'hEE;
    @(posedge clk); #1;
    rq1_addr = 8'h2B;
    wait_ack(1, "loser_ack_in_time");
    rq1_req = 1'b0;
    @(posedge clk); #1;

    // reset during STROBE: aborted write, no ack ever
    set_port(0, 1'b1, 1'b1, 8'h77, 8'h99);
    @(posedge clk);
    @(posedge clk); #2;
    chk("abort_strobe_pre", sfr_write_valid, 1);
    nrst = 1'b0;
    #1;
    reset_checks("abort");
    rq0_req = 1'b0;
    @(negedge clk); #2;
    nrst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("abort_no_ack",  rq0_ack, 0);
      chk("abort_idle",    busy, 0);
    end

    chk("queue_a_drained", q.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
